// File: rtl/kmp_ff_gen_pkg.sv
// kmp_ff_gen_pkg: shared sizing constants and FSM state type for the KMP
// failure-function generator.
//   MAX_PATTERN : maximum pattern length in characters
//   BYTE        : bits per character
//   MAX_PAT_ADD : character index width (2**MAX_PAT_ADD >= MAX_PATTERN)
package kmp_ff_gen_pkg;

  localparam int unsigned MAX_PATTERN = 8;
  localparam int unsigned BYTE        = 8;
  localparam int unsigned MAX_PAT_ADD = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/kmp_ff_gen_if.sv
// kmp_ff_gen_if: request/result bundle between the pattern source (master)
// and the failure-function generator (slave).
//   pat_input     : packed pattern, char k at [k*BYTE +: BYTE]
//   pat_last_idx  : index of the last valid character
//   input_valid   : level-held request
//   output_valid  : ff_result valid
//   ff_result     : entry k at [k*MAX_PAT_ADD +: MAX_PAT_ADD]
interface kmp_ff_gen_if;
  import kmp_ff_gen_pkg::*;

  logic [MAX_PATTERN*BYTE-1:0]        pat_input;
  logic [MAX_PAT_ADD-1:0]             pat_last_idx;
  logic                               input_valid;
  logic                               output_valid;
  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result;

  modport master (
    output pat_input, pat_last_idx, input_valid,
    input  output_valid, ff_result
  );

  modport slave (
    input  pat_input, pat_last_idx, input_valid,
    output output_valid, ff_result
  );

endinterface

// File: rtl/kmp_ff_gen.sv
// kmp_ff_gen: KMP failure-function (prefix table) generator. Latches the
// pattern on INIT, performs one KMP table-construction step per COMP cycle,
// and raises output_valid from DONE while the request is still held.
// Ports:
//   clk       : clock
//   reset     : synchronous, active-high reset
//   bus       : kmp_ff_gen_if.slave (pattern in, ff_result / output_valid out)
//   ff_cycles : number of COMP steps taken (only with KMP_FF_CYCLE_CNT_EN)
// Optional feature macro: KMP_FF_CYCLE_CNT_EN
module kmp_ff_gen
  import kmp_ff_gen_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
`ifdef KMP_FF_CYCLE_CNT_EN
  output logic [MAX_PAT_ADD+1:0] ff_cycles,
`endif
  kmp_ff_gen_if.slave            bus
);

  state_t state_q, state_d;

  logic [MAX_PATTERN*BYTE-1:0]        pat_q;
  logic [MAX_PAT_ADD-1:0]             last_q;
  logic [MAX_PAT_ADD:0]               i_q;    // one extra bit so it cannot wrap past the last index
  logic [MAX_PAT_ADD-1:0]             len_q;
  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_q;
  logic                               ov_q;

  logic [MAX_PAT_ADD-1:0] i_idx;
  logic                   past_last;
  logic                   match;
  logic                   step_writes_last;
  logic                   ov_d;

  function automatic logic [BYTE-1:0] char_at(
    input logic [MAX_PATTERN*BYTE-1:0] p,
    input logic [MAX_PAT_ADD-1:0]      idx
  );
    return p[idx*BYTE +: BYTE];
  endfunction

  function automatic logic [MAX_PAT_ADD-1:0] ff_at(
    input logic [MAX_PAT_ADD*MAX_PATTERN-1:0] f,
    input logic [MAX_PAT_ADD-1:0]             idx
  );
    return f[idx*MAX_PAT_ADD +: MAX_PAT_ADD];
  endfunction

  // Step decode and registered-output next value
  always_comb begin
    i_idx            = i_q[MAX_PAT_ADD-1:0];
    past_last        = i_q > {1'b0, last_q};
    match            = char_at(pat_q, i_idx) == char_at(pat_q, len_q);
    // Only match and len==0 steps write an entry; a fallback step never finishes
    step_writes_last = !past_last && (match || (len_q == '0)) && (i_idx == last_q);
    ov_d             = (state_q == DONE) && bus.input_valid;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.input_valid) state_d = INIT;
      INIT: state_d = COMP;
      COMP: if (past_last || step_writes_last) state_d = DONE;
      DONE: if (!bus.input_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      last_q <= '0;
      i_q    <= (MAX_PAT_ADD+1)'(1);
      len_q  <= '0;
      ff_q   <= '0;
      ov_q   <= 1'b0;
`ifdef KMP_FF_CYCLE_CNT_EN
      ff_cycles <= '0;
`endif
    end else begin
      ov_q <= ov_d;
      unique case (state_q)
        INIT: begin
          pat_q  <= bus.pat_input;
          last_q <= bus.pat_last_idx;
          i_q    <= (MAX_PAT_ADD+1)'(1);
          len_q  <= '0;
          ff_q   <= '0;
`ifdef KMP_FF_CYCLE_CNT_EN
          ff_cycles <= '0;
`endif
        end
        COMP: begin
`ifdef KMP_FF_CYCLE_CNT_EN
          ff_cycles <= ff_cycles + 1'b1;
`endif
          if (!past_last) begin
            if (match) begin
              ff_q[i_idx*MAX_PAT_ADD +: MAX_PAT_ADD] <= len_q + 1'b1;
              len_q <= len_q + 1'b1;
              i_q   <= i_q + 1'b1;
            end else if (len_q != '0) begin
              len_q <= ff_at(ff_q, len_q - 1'b1);
            end else begin
              ff_q[i_idx*MAX_PAT_ADD +: MAX_PAT_ADD] <= '0;
              i_q <= i_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.output_valid = ov_q;
  assign bus.ff_result    = ff_q;

endmodule

// File: tb/tb_kmp_ff_gen.sv
// tb_kmp_ff_gen: self-checking bench for kmp_ff_gen. Expected tables come
// from a brute-force longest-border search; step counts from a software KMP
// loop over that table. Honours KMP_FF_CYCLE_CNT_EN.
module tb_kmp_ff_gen;
  import kmp_ff_gen_pkg::*;

  localparam int unsigned PW = MAX_PATTERN*BYTE;
  localparam int unsigned FW = MAX_PAT_ADD*MAX_PATTERN;

  logic clk = 1'b0;
  logic reset;

  kmp_ff_gen_if bus();

`ifdef KMP_FF_CYCLE_CNT_EN
  logic [MAX_PAT_ADD+1:0] ff_cycles;
`endif

  kmp_ff_gen dut (
    .clk       (clk),
    .reset     (reset),
`ifdef KMP_FF_CYCLE_CNT_EN
    .ff_cycles (ff_cycles),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            chk_en    = 1'b0;
  logic          exp_ov    = 1'b0;
  bit            ff_known  = 1'b0;
  bit            cyc_known = 1'b0;
  logic [FW-1:0] exp_ff    = '0;
  int            exp_cyc   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack(input string s);
    logic [PW-1:0] p = '0;
    for (int k = 0; k < s.len(); k++) p[k*BYTE +: BYTE] = s[k];
    return p;
  endfunction

  // Border table by exhaustive comparison; N from a plain KMP loop using it.
  task automatic model(input logic [PW-1:0] p, input int last,
                       output logic [FW-1:0] f, output int n);
    int fv[MAX_PATTERN];
    int len, i;
    for (int k = 0; k < int'(MAX_PATTERN); k++) fv[k] = 0;
    for (int k = 1; k <= last; k++) begin
      bit found = 1'b0;
      for (int b = k; b >= 1; b--) begin
        bit ok = 1'b1;
        for (int j = 0; j < b; j++)
          if (p[j*BYTE +: BYTE] != p[(k-b+1+j)*BYTE +: BYTE]) ok = 1'b0;
        if (ok && !found) begin
          fv[k] = b;
          found = 1'b1;
        end
      end
    end
    f = '0;
    for (int k = 0; k < int'(MAX_PATTERN); k++) f[k*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(fv[k]);
    if (last == 0) n = 1;
    else begin
      n = 0; len = 0; i = 1;
      while (i <= last) begin
        n++;
        if (p[i*BYTE +: BYTE] == p[len*BYTE +: BYTE]) begin len++; i++; end
        else if (len != 0) len = fv[len-1];
        else i++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("output_valid", 64'(bus.output_valid), 64'(exp_ov));
      if (ff_known) check("ff_result", 64'(bus.ff_result), 64'(exp_ff));
`ifdef KMP_FF_CYCLE_CNT_EN
      if (cyc_known) check("ff_cycles", 64'(ff_cycles), 64'(exp_cyc));
`endif
    end
  end

  // One request. Edge k counts from the edge that samples input_valid in
  // IDLE. Input drops after edge d; early<=n+1 drops mid-computation,
  // otherwise it is held for hold cycles after output_valid rises.
  task automatic do_req(input logic [PW-1:0] p, input int last, input int early,
                        input int hold, input int rst_at, input bit perturb);
    logic [FW-1:0] mf;
    int n, d, fin;
    model(p, last, mf, n);
    d   = (early >= 0 && early <= n+1) ? early : n + 2 + hold;
    fin = (d + 1 > n + 2) ? d + 1 : n + 2;
    @(negedge clk);
    bus.pat_input    = p;
    bus.pat_last_idx = MAX_PAT_ADD'(last);
    bus.input_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (rst_at >= 0 && k == rst_at + 1) begin
        exp_ov = 1'b0; ff_known = 1'b1; exp_ff = '0; cyc_known = 1'b1; exp_cyc = 0;
        reset = 1'b0;
        return;
      end
      exp_ov = (k >= n + 2) && (k <= d);
      if (k == 1) begin ff_known = 1'b1; exp_ff = '0; end
      else if (k >= n + 1) begin ff_known = 1'b1; exp_ff = mf; end
      else if (k >= 2) ff_known = 1'b0;
      if (k >= 1) begin cyc_known = 1'b1; exp_cyc = (k - 1 < n) ? k - 1 : n; end
      if (k >= fin) return;
      if (k == d) bus.input_valid = 1'b0;
      if (rst_at >= 0 && k == rst_at) begin reset = 1'b1; bus.input_valid = 1'b0; end
      if (perturb && k >= 1) begin
        bus.pat_input    = PW'({$urandom, $urandom});
        bus.pat_last_idx = MAX_PAT_ADD'($urandom_range(0, MAX_PATTERN-1));
      end
    end
    errors++;
    $display("FAIL txn_bound: transaction did not complete within 200 cycles");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    logic [PW-1:0] p;
    int n;
    reset            = 1'b1;
    bus.input_valid  = 1'b0;
    bus.pat_input    = '0;
    bus.pat_last_idx = '0;

    model(pack("aaaa"), 3, f, n);
    check("model_aaaa_ff", 64'(f), 64'd1672);
    check("model_aaaa_n", 64'(n), 64'd3);
    model(pack("abab"), 3, f, n);
    check("model_abab_ff", 64'(f), 64'd1088);
    check("model_abab_n", 64'(n), 64'd3);
    model(pack("aabaaab"), 6, f, n);
    check("model_aabaaab_ff", 64'(f), 64'd860680);
    check("model_aabaaab_n", 64'(n), 64'd8);
    model(pack("x"), 0, f, n);
    check("model_x_ff", 64'(f), 64'd0);
    check("model_x_n", 64'(n), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_ov    = 1'b0;
    ff_known  = 1'b1;
    exp_ff    = '0;
    cyc_known = 1'b1;
    exp_cyc   = 0;
    chk_en    = 1'b1;

    do_req(pack("aaaa"),    3, -1, 2, -1, 1'b0);
    do_req(pack("abab"),    3, -1, 1, -1, 1'b0);
    do_req(pack("aabaaab"), 6, -1, 1, -1, 1'b0);
    do_req(pack("x"),       0, -1, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    do_req(pack("abab"),    3,  3, 0, -1, 1'b0);
    do_req(pack("aaaa"),    3, -1, 1, -1, 1'b0);
    do_req(pack("aabaaab"), 6, -1, 0,  3, 1'b0);
    do_req(pack("aabaaab"), 6, -1, 1, -1, 1'b1);

    for (int t = 0; t < 60; t++) begin
      int alph = $urandom_range(1, 2);
      for (int k = 0; k < int'(MAX_PATTERN); k++)
        p[k*BYTE +: BYTE] = 8'h61 + BYTE'($urandom_range(0, alph));
      do_req(p, $urandom_range(0, MAX_PATTERN-1), $urandom_range(0, 20),
             $urandom_range(0, 2),
             ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
